// File: rtl/sdf_bf_stage_32.sv
// Radix-2 single-path delay-feedback DIF butterfly stage, 64-point span, one sample per clock.
// Consumes the twiddle ROM phase and coefficients aligned with din; results are registered.
module sdf_bf_stage_32 #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] din_r,
  input  logic signed [WIDTH-1:0] din_i,
  input  logic [1:0]              state,
  input  logic signed [WIDTH-1:0] w_r,
  input  logic signed [WIDTH-1:0] w_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] dout_r,
  output logic signed [WIDTH-1:0] dout_i
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW  = WIDTH + 1;
  localparam int unsigned PRW = 2 * WIDTH;
  localparam int unsigned ACW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_BFLY = 2'd1,
    PH_TWID = 2'd2,
    PH_RSVD = 2'd3
  } phase_e;

  phase_e phase;
  assign phase = phase_e'(state);

  logic signed [WIDTH-1:0] line_r [DEPTH];
  logic signed [WIDTH-1:0] line_i [DEPTH];
  logic [PW-1:0]           ptr;

  logic signed [WIDTH-1:0] head_r, head_i;
  logic signed [SW-1:0]    sum_r, sum_i, diff_r, diff_i;
  logic signed [PRW-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [ACW-1:0]   acc_r, acc_i;
  logic signed [WIDTH-1:0] tw_r, tw_i;

  logic                    adv;
  logic signed [WIDTH-1:0] push_r, push_i;
  logic                    nxt_out_valid;
  logic signed [WIDTH-1:0] nxt_dout_r, nxt_dout_i;
  logic                    unused_bits;

  assign head_r = line_r[ptr];
  assign head_i = line_i[ptr];

  // Butterfly add/sub one bit wider, then wrapped back to WIDTH
  always_comb begin
    sum_r  = SW'(head_r) + SW'(din_r);
    sum_i  = SW'(head_i) + SW'(din_i);
    diff_r = SW'(head_r) - SW'(din_r);
    diff_i = SW'(head_i) - SW'(din_i);
  end

  // Complex twiddle multiply on the head word; floor rounding via arithmetic shift
  always_comb begin
    p_rr  = PRW'(head_r) * PRW'(w_r);
    p_ii  = PRW'(head_i) * PRW'(w_i);
    p_ri  = PRW'(head_r) * PRW'(w_i);
    p_ir  = PRW'(head_i) * PRW'(w_r);
    acc_r = ACW'(p_rr) - ACW'(p_ii);
    acc_i = ACW'(p_ri) + ACW'(p_ir);
    tw_r  = acc_r[FRAC+WIDTH-1:FRAC];
    tw_i  = acc_i[FRAC+WIDTH-1:FRAC];
  end

  assign unused_bits = ^{sum_r[SW-1], sum_i[SW-1], diff_r[SW-1], diff_i[SW-1],
                         acc_r[ACW-1:FRAC+WIDTH], acc_i[ACW-1:FRAC+WIDTH],
                         acc_r[FRAC-1:0], acc_i[FRAC-1:0]};

  // Phase decode: what goes into the line and what comes out this cycle
  always_comb begin
    adv           = 1'b0;
    push_r        = din_r;
    push_i        = din_i;
    nxt_out_valid = 1'b0;
    nxt_dout_r    = dout_r;
    nxt_dout_i    = dout_i;
    case (phase)
      PH_BFLY: begin
        adv           = 1'b1;
        push_r        = diff_r[WIDTH-1:0];
        push_i        = diff_i[WIDTH-1:0];
        nxt_out_valid = 1'b1;
        nxt_dout_r    = sum_r[WIDTH-1:0];
        nxt_dout_i    = sum_i[WIDTH-1:0];
      end
      PH_TWID: begin
        adv           = 1'b1;
        nxt_out_valid = 1'b1;
        nxt_dout_r    = tw_r;
        nxt_dout_i    = tw_i;
      end
      default: begin
        adv = in_valid;
      end
    endcase
  end

  // Delay line, shared read/write pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        line_r[i] <= '0;
        line_i[i] <= '0;
      end
      ptr       <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      if (adv) begin
        line_r[ptr] <= push_r;
        line_i[ptr] <= push_i;
        ptr         <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
      end
      out_valid <= nxt_out_valid;
      dout_r    <= nxt_dout_r;
      dout_i    <= nxt_dout_i;
    end
  end

endmodule
